imem_loader: RTL and testbench

- Writer-side counterpart of the instruction memory: fills instruction memory at boot from a byte stream, e.g. from a UART receiver.
- Accepts a length header plus little-endian instruction bytes, assembles 32-bit words and drives a single-cycle write port at consecutive word-aligned addresses.
- Holds the CPU in reset (cpu_hold) while loading; flags completion or an oversize image.

---
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader.sv | 122 ++++++++++++
 tb/tb_imem_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream in / instruction-memory write out bundle for imem_loader.
// master = stream source + memory/CPU side observer, slave = the loader.
interface imem_loader_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             in_valid;
   logic [7:0]       in_data;
   logic             in_ready;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic             cpu_hold;
   logic             done;
   logic             error;
   logic [15:0]      word_count;

   modport master (
      output start, in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, word_count
   );

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, word_count
   );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length header + little-endian bytes -> 32-bit instruction memory writes,
// holding the CPU in reset while the image streams in.
module imem_loader #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64
) (
   input logic          clk,
   input logic          rst,
   imem_loader_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      DONE,
      ERROR
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       byte_idx_q, byte_idx_d;
   logic [23:0]      asm_q, asm_d;
   logic [15:0]      len_q, len_d;
   logic [15:0]      wc_q, wc_d;
   logic             we_q, we_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;

   logic             in_ready;
   logic             xfer;
   logic [15:0]      len_n;

   assign in_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                     (state_q == DATA)   || (state_q == ERROR);
   assign xfer     = bus.in_valid && in_ready;
   assign len_n    = {bus.in_data, len_q[7:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         byte_idx_q <= '0;
         asm_q      <= '0;
         len_q      <= '0;
         wc_q       <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         asm_q      <= asm_d;
         len_q      <= len_d;
         wc_q       <= wc_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      asm_d      = asm_q;
      len_d      = len_q;
      wc_d       = wc_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;

      case (state_q)
         IDLE, DONE, ERROR: begin
            if (bus.start) begin
               state_d    = LEN_LO;
               wc_d       = '0;
               byte_idx_d = '0;
            end
         end
         LEN_LO: begin
            if (xfer) begin
               len_d[7:0] = bus.in_data;
               state_d    = LEN_HI;
            end
         end
         LEN_HI: begin
            if (xfer) begin
               len_d      = len_n;
               byte_idx_d = '0;
               if (len_n == 16'd0)             state_d = DONE;
               else if (len_n > 16'(DEPTH))    state_d = ERROR;
               else                            state_d = DATA;
            end
         end
         DATA: begin
            // word_count already counts the word being written, so equality marks the last one
            if (we_q && (wc_q == len_q)) begin
               state_d = DONE;
            end else if (xfer) begin
               asm_d      = {bus.in_data, asm_q[23:8]};
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  we_d    = 1'b1;
                  addr_d  = WIDTH'({wc_q, 2'b00});
                  wdata_d = WIDTH'({bus.in_data, asm_q});
                  wc_d    = wc_q + 16'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready   = in_ready;
   assign bus.mem_we     = we_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.cpu_hold   = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
   assign bus.done       = (state_q == DONE);
   assign bus.error      = (state_q == ERROR);
   assign bus.word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header/data byte streams with hand-computed writes.
module tb_imem_loader;

   logic clk = 1'b0;
   logic rst = 1'b1;

   imem_loader_if #(.WIDTH(32)) bus ();

   imem_loader #(.WIDTH(32), .DEPTH(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [31:0] img     [0:79];
   logic [31:0] wr_addr [0:79];
   logic [31:0] wr_data [0:79];
   int unsigned wr_cnt = 0;

   always @(negedge clk) begin
      if (bus.mem_we) begin
         if (wr_cnt < 80) begin
            wr_addr[wr_cnt] = bus.mem_addr;
            wr_data[wr_cnt] = bus.mem_wdata;
         end
         wr_cnt = wr_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Called at a negedge; returns at a negedge after the byte was accepted.
   task automatic send_byte(input logic [7:0] b, input int unsigned gap, input logic exp_we);
      int unsigned t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) check("ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      check("we_latency", {31'd0, bus.mem_we}, {31'd0, exp_we});
      if (gap > 0) begin
         bus.in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic load(input int unsigned nwords, input int unsigned gap);
      wr_cnt = 0;
      pulse_start();
      check("hold_after_start", {31'd0, bus.cpu_hold}, 32'd1);
      send_byte(nwords[7:0], gap, 1'b0);
      send_byte(nwords[15:8], gap, 1'b0);
      for (int unsigned w = 0; w < nwords; w++) begin
         for (int unsigned b = 0; b < 4; b++) begin
            logic [31:0] word;
            word = img[w];
            send_byte(word[8*b +: 8], (w == nwords - 1 && b == 3) ? 0 : gap, b == 3);
         end
      end
      bus.in_valid = 1'b0;
      check("done_in_we_cycle", {31'd0, bus.done}, 32'd0);
      @(negedge clk);
      check("done", {31'd0, bus.done}, 32'd1);
      check("hold_released", {31'd0, bus.cpu_hold}, 32'd0);
      check("no_extra_we", {31'd0, bus.mem_we}, 32'd0);
      check("word_count", {16'd0, bus.word_count}, nwords);
      check("write_count", wr_cnt, nwords);
      for (int unsigned i = 0; i < nwords && i < 80; i++) begin
         check("wr_addr", wr_addr[i], i * 4);
         check("wr_data", wr_data[i], img[i]);
      end
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;

      // Reset with a byte offered
      repeat (2) @(negedge clk);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("rst_addr", bus.mem_addr, 32'd0);
      check("rst_wdata", bus.mem_wdata, 32'd0);
      check("rst_hold", {31'd0, bus.cpu_hold}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_error", {31'd0, bus.error}, 32'd0);
      check("rst_wc", {16'd0, bus.word_count}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("idle_hold", {31'd0, bus.cpu_hold}, 32'd0);
      bus.in_valid = 1'b0;
      check("rst_no_writes", wr_cnt, 32'd0);

      // Normal back-to-back load
      img[0] = 32'h0000_0013;
      img[1] = 32'h0050_00B3;
      load(2, 0);

      // Same image with 3-cycle gaps between bytes, restarted from DONE
      load(2, 3);

      // N = 0
      wr_cnt = 0;
      pulse_start();
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      bus.in_valid = 1'b0;
      check("n0_done", {31'd0, bus.done}, 32'd1);
      check("n0_wc", {16'd0, bus.word_count}, 32'd0);
      @(negedge clk);
      check("n0_no_writes", wr_cnt, 32'd0);

      // N = 65: oversize, following bytes drained
      pulse_start();
      send_byte(8'h41, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      check("ovr_error", {31'd0, bus.error}, 32'd1);
      check("ovr_hold", {31'd0, bus.cpu_hold}, 32'd0);
      check("ovr_in_ready", {31'd0, bus.in_ready}, 32'd1);
      for (int unsigned i = 0; i < 6; i++) send_byte(8'h5A, 0, 1'b0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("ovr_still_error", {31'd0, bus.error}, 32'd1);
      check("ovr_no_writes", wr_cnt, 32'd0);

      // N = DEPTH, restarted from ERROR
      for (int unsigned i = 0; i < 64; i++) img[i] = i;
      load(64, 0);
      check("last_addr", wr_addr[63], 32'd252);
      check("last_data", wr_data[63], 32'h0000_003F);

      // Restart from DONE loads from address 0 again
      img[0] = 32'hDEAD_BEEF;
      load(1, 1);

      // Reset after 5 data bytes of a 2-word image
      wr_cnt = 0;
      pulse_start();
      send_byte(8'h02, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h11, 0, 1'b0);
      send_byte(8'h22, 0, 1'b0);
      send_byte(8'h33, 0, 1'b0);
      send_byte(8'h44, 0, 1'b1);
      send_byte(8'h55, 0, 1'b0);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_hold", {31'd0, bus.cpu_hold}, 32'd0);
      check("mid_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("mid_done", {31'd0, bus.done}, 32'd0);
      check("mid_wc", {16'd0, bus.word_count}, 32'd0);
      repeat (4) @(negedge clk);
      check("mid_write_count", wr_cnt, 32'd1);
      check("mid_wr_addr", wr_addr[0], 32'd0);
      check("mid_wr_data", wr_data[0], 32'h4433_2211);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
